// File: rtl/servo_pwm_slew.sv
// rtl/servo_pwm_slew.sv - servo pulse generator with clamped, rate-limited width
// Width changes land only on period ticks so every pulse carries a single width.
module servo_pwm_slew #(
  parameter int WIDTH       = 21,
  parameter int MIN_PULSE   = 50000,
  parameter int MAX_PULSE   = 100000,
  parameter int RESET_PULSE = 75000,
  parameter int STEP        = 500
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             period_tick_in,
  input  logic             target_valid_in,
  input  logic [WIDTH-1:0] target_in,
  output logic             pwm_out,
  output logic [WIDTH-1:0] width_out,
  output logic             at_target_out
);

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_PULSE);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_PULSE);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PULSE);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             at_target_q, at_target_d;

  logic [WIDTH-1:0] target_clamped;
  logic [WIDTH:0]   diff_up, diff_dn;

  always_comb begin
    target_clamped = target_in;
    if (target_in < MIN_W) begin
      target_clamped = MIN_W;
    end else if (target_in > MAX_W) begin
      target_clamped = MAX_W;
    end
    target_d = target_valid_in ? target_clamped : target_q;
  end

  // The step always uses the target held before this edge; a capture on a
  // tick cycle only influences the following tick.
  always_comb begin
    diff_up  = {1'b0, target_q} - {1'b0, active_q};
    diff_dn  = {1'b0, active_q} - {1'b0, target_q};
    active_d = active_q;
    if (period_tick_in) begin
      if (target_q > active_q) begin
        active_d = (diff_up <= STEP_X) ? target_q : active_q + STEP_W;
      end else if (target_q < active_q) begin
        active_d = (diff_dn <= STEP_X) ? target_q : active_q - STEP_W;
      end
    end
  end

  // Compare against the width in force before the edge; count 0 is high for
  // any legal width, so the boundary cycle never mixes two widths.
  always_comb begin
    pwm_d       = (count_in < active_q);
    at_target_d = (active_d == target_d);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      target_q    <= RESET_W;
      active_q    <= RESET_W;
      pwm_q       <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      target_q    <= target_d;
      active_q    <= active_d;
      pwm_q       <= pwm_d;
      at_target_q <= at_target_d;
    end
  end

  assign pwm_out       = pwm_q;
  assign width_out     = active_q;
  assign at_target_out = at_target_q;

endmodule

// File: tb/tb_servo_pwm_slew.sv
// tb/tb_servo_pwm_slew.sv - bench for servo_pwm_slew against a cycle-level reference model
module tb_servo_pwm_slew;
  localparam int W    = 21;
  localparam int MINP = 50;
  localparam int MAXP = 100;
  localparam int RP   = 75;
  localparam int STP  = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         tvalid;
  logic [W-1:0] count;
  logic [W-1:0] tgt_in;
  logic         pwm;
  logic [W-1:0] width;
  logic         at_tgt;

  always #5 clk = ~clk;

  servo_pwm_slew #(
    .WIDTH(W), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .RESET_PULSE(RP), .STEP(STP)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .count_in(count),
    .period_tick_in(tick),
    .target_valid_in(tvalid),
    .target_in(tgt_in),
    .pwm_out(pwm),
    .width_out(width),
    .at_target_out(at_tgt)
  );

  int vectors = 0;
  int miscompares = 0;
  int m_tgt = RP, m_act = RP, m_pwm = 0, m_at = 1;
  int cnt = 0;
  int period = 1000;
  int hi_acc = 0;
  int widths_q[$];
  int exp_q[$];

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampv(input int v);
    if (v < MINP) return MINP;
    if (v > MAXP) return MAXP;
    return v;
  endfunction

  // One clock: predict the post-edge state from the rules, then compare.
  task automatic step();
    int n_tgt, n_act, delta;
    count = W'(cnt);
    tick  = (cnt == 0);
    if (rst) begin
      n_tgt = RP;
      n_act = RP;
      m_pwm = 0;
    end else begin
      n_tgt = tvalid ? clampv(int'(tgt_in)) : m_tgt;
      n_act = m_act;
      if (tick) begin
        delta = m_tgt - m_act;
        if (delta > STP)  delta = STP;
        if (delta < -STP) delta = -STP;
        n_act = m_act + delta;
      end
      m_pwm = (cnt < m_act) ? 1 : 0;
    end
    m_at  = (n_act == n_tgt) ? 1 : 0;
    m_tgt = n_tgt;
    m_act = n_act;
    @(posedge clk);
    #1;
    check_val("pwm_out", int'(pwm), m_pwm);
    check_val("width_out", int'(width), m_act);
    check_val("at_target_out", int'(at_tgt), m_at);
    if (rst) begin
      hi_acc = 0;
    end else begin
      if (cnt == 0) begin
        widths_q.push_back(hi_acc);
        hi_acc = 0;
      end
      hi_acc += int'(pwm);
    end
    cnt    = rst ? 0 : (cnt + 1) % period;
    tvalid = 1'b0;
  endtask

  task automatic wait_count(input int c);
    for (int i = 0; i < 2 * period + 2 && cnt != c; i++) step();
    if (cnt != c) check_val("wait_count_timeout", cnt, c);
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < (n + 2) * period && widths_q.size() < n; i++) step();
    if (widths_q.size() < n) check_val("collect_timeout", widths_q.size(), n);
  endtask

  task automatic expect_widths(input string tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < widths_q.size()) check_val($sformatf("%s_pulse%0d", tag, i), widths_q[i], exp_q[i]);
    end
  endtask

  task automatic issue(input int v);
    tvalid = 1'b1;
    tgt_in = W'(v);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    tvalid = 1'b0;
    tgt_in = '0;
    count  = '0;
    tick   = 1'b1;
    do_reset();
    check_val("reset_width", int'(width), 75);
    check_val("reset_at_target", int'(at_tgt), 1);
    check_val("reset_pwm", int'(pwm), 0);

    // Idle: fixed 75-cycle pulses
    wait_count(1);
    widths_q.delete();
    collect(3);
    exp_q = '{75, 75, 75};
    expect_widths("idle");

    // Target 90 mid-period
    wait_count(1);
    widths_q.delete();
    wait_count(500);
    issue(90);
    check_val("t90_at_drop", int'(at_tgt), 0);
    collect(5);
    exp_q = '{75, 80, 85, 90, 90};
    expect_widths("t90");
    check_val("t90_width", int'(width), 90);
    check_val("t90_at_rise", int'(at_tgt), 1);

    // Clamp low then high
    do_reset();
    wait_count(1);
    widths_q.delete();
    wait_count(300);
    issue(20);
    collect(7);
    exp_q = '{75, 70, 65, 60, 55, 50, 50};
    expect_widths("clamp_lo");
    widths_q.delete();
    wait_count(300);
    issue(500);
    collect(12);
    exp_q.delete();
    for (int k = 0; k <= 10; k++) exp_q.push_back(50 + 5 * k);
    exp_q.push_back(100);
    expect_widths("clamp_hi");

    // Capture coinciding with the tick uses the old target for that step
    do_reset();
    wait_count(500);
    issue(90);
    wait_count(0);
    issue(60);
    widths_q.delete();
    collect(5);
    exp_q = '{80, 75, 70, 65, 60};
    expect_widths("same_cycle");
    check_val("same_cycle_width", int'(width), 60);

    // Partial final step
    do_reset();
    wait_count(1);
    widths_q.delete();
    wait_count(400);
    issue(77);
    collect(3);
    exp_q = '{75, 77, 77};
    expect_widths("partial_step");

    // Reset 30 cycles into a 90-cycle pulse
    do_reset();
    wait_count(1);
    widths_q.delete();
    wait_count(400);
    issue(90);
    collect(4);
    wait_count(30);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("midreset_pwm", int'(pwm), 0);
    check_val("midreset_width", int'(width), 75);
    check_val("midreset_at", int'(at_tgt), 1);
    wait_count(1);
    widths_q.delete();
    collect(2);
    exp_q = '{75, 75};
    expect_widths("after_reset");

    // Randomized targets, periods (including period <= width) and resets
    for (int r = 0; r < 6; r++) begin
      wait_count(0);
      case ($urandom_range(0, 3))
        0:       period = 60;
        1:       period = 97;
        2:       period = 150;
        default: period = 400;
      endcase
      for (int i = 0; i < 2000; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          tvalid = 1'b1;
          tgt_in = W'($urandom_range(0, 160));
        end
        rst = ($urandom_range(0, 1999) == 0);
        step();
      end
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
